// File: rtl/morse_message_sequencer_if.sv
// morse_message_sequencer_if
//   Bundles the buffer write port, playback control and status/laser outputs
//   of morse_message_sequencer.
//   master : the controller/host side (drives writes, start, abort, repeat).
//   slave  : the sequencer side (drives busy, done, char_idx, ONOFF, isDash).
//   Signals:
//     wr_en, wr_addr, wr_pattern, wr_len : message buffer write port
//     msg_len, start, repeat_en, abort   : playback control
//     busy, done, char_idx               : playback status
//     ONOFF, isDash                      : laser drive and dash indicator
interface morse_message_sequencer_if #(
  parameter int PAT_W = 20,
  parameter int LEN_W = 5,
  parameter int IDX_W = 4
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [PAT_W-1:0] wr_pattern;
  logic [LEN_W-1:0] wr_len;
  logic [IDX_W:0]   msg_len;
  logic             start;
  logic             repeat_en;
  logic             abort;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] char_idx;
  logic             ONOFF;
  logic             isDash;

  modport master (
    output wr_en, wr_addr, wr_pattern, wr_len, msg_len, start, repeat_en, abort,
    input  busy, done, char_idx, ONOFF, isDash
  );

  modport slave (
    input  wr_en, wr_addr, wr_pattern, wr_len, msg_len, start, repeat_en, abort,
    output busy, done, char_idx, ONOFF, isDash
  );
endinterface

// File: rtl/morse_message_sequencer.sv
// morse_message_sequencer
//   Plays a Morse message stored in a writable buffer on the laser ON/OFF
//   line, one Morse unit per UnitClock edge. Each buffer entry is either a
//   character pattern (bit0 sent first, 1 = light on) with a length, or a
//   word space (length 0). Supports start/busy/done handshake, abort, repeat
//   mode and a dash indicator. All outputs are registered.
//   Ports:
//     UnitClock : unit clock, one Morse unit per rising edge
//     reset     : synchronous, active-high
//     bus       : morse_message_sequencer_if.slave (write port, control,
//                 status, ONOFF, isDash)
//   Build option:
//     MORSE_FARNSWORTH_EN : when defined, every gap (inter-character,
//                           word space, repeat gap) is stretched by GAP_MULT.
module morse_message_sequencer #(
  parameter int MAX_CHARS = 16,
  parameter int PAT_W     = 20,
  parameter int LEN_W     = 5,
  parameter int IDX_W     = 4,
  parameter int CHAR_GAP  = 3,
  parameter int WORD_GAP  = 7,
  parameter int GAP_MULT  = 2
) (
  input logic                      UnitClock,
  input logic                      reset,
  morse_message_sequencer_if.slave bus
);

`ifdef MORSE_FARNSWORTH_EN
  localparam int MULT = GAP_MULT;
`else
  // GAP_MULT has no effect in this build.
  localparam int MULT = 1 + 0 * GAP_MULT;
`endif

  localparam int CG_UNITS = CHAR_GAP * MULT;
  localparam int SG_UNITS = (WORD_GAP - CHAR_GAP) * MULT;
  localparam int GAP_MAX  = WORD_GAP * MULT;
  localparam int GAP_CW   = $clog2(GAP_MAX + 1);
  localparam int CNT_W    = (LEN_W > GAP_CW) ? LEN_W : GAP_CW;
  localparam int ML_W     = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, CHAR, GAP, SPACE, REP_GAP} state_t;

  // Message buffer (not reset)
  logic [PAT_W-1:0] r_pat  [MAX_CHARS];
  logic [LEN_W-1:0] r_blen [MAX_CHARS];

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [ML_W-1:0]  r_msglen, w_msglen;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_onoff, w_onoff;
  logic             r_dash, w_dash;
  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_advance;
  logic             w_last;

  function automatic logic [LEN_W-1:0] f_sat_len(input logic [LEN_W-1:0] l);
    if (int'(l) > PAT_W) return LEN_W'(PAT_W);
    return l;
  endfunction

  function automatic logic [ML_W-1:0] f_sat_msg(input logic [ML_W-1:0] m);
    if (int'(m) > MAX_CHARS) return ML_W'(MAX_CHARS);
    return m;
  endfunction

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // Pattern bit at pos; positions outside [0, len-1] read as 0.
  function automatic logic f_bit(input logic [PAT_W-1:0] pat,
                                 input logic [LEN_W-1:0] len,
                                 input int               pos);
    logic [PAT_W-1:0] sh;
    if (pos < 0 || pos >= int'(len)) return 1'b0;
    sh = pat >> pos;
    return sh[0];
  endfunction

  // Buffer write port, locked while playing.
  always_ff @(posedge UnitClock) begin
    if (bus.wr_en && !r_busy) begin
      r_pat[bus.wr_addr]  <= bus.wr_pattern;
      r_blen[bus.wr_addr] <= f_sat_len(bus.wr_len);
    end
  end

  // Next state and next registered outputs
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_msglen   = r_msglen;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_load     = 1'b0;
    w_load_idx = '0;
    w_advance  = 1'b0;
    w_onoff    = 1'b0;
    w_dash     = 1'b0;
    w_last     = (int'(r_idx) == int'(r_msglen) - 1);

    if (bus.abort) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_idx   = '0;
      w_busy  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_msglen = f_sat_msg(bus.msg_len);
            w_idx    = '0;
            if (w_msglen == '0) begin
              w_done = 1'b1;
            end else begin
              w_busy     = 1'b1;
              w_load     = 1'b1;
              w_load_idx = '0;
            end
          end
        end
        CHAR: begin
          if (int'(r_cnt) >= int'(r_blen[r_idx]) - 1) begin
            w_state = GAP;
            w_cnt   = '0;
          end else begin
            w_cnt = f_inc(r_cnt);
          end
        end
        GAP: begin
          if (int'(r_cnt) >= CG_UNITS - 1) w_advance = 1'b1;
          else                              w_cnt = f_inc(r_cnt);
        end
        SPACE: begin
          if (int'(r_cnt) >= SG_UNITS - 1) w_advance = 1'b1;
          else                              w_cnt = f_inc(r_cnt);
        end
        REP_GAP: begin
          if (int'(r_cnt) >= SG_UNITS - 1) begin
            w_load     = 1'b1;
            w_load_idx = '0;
          end else begin
            w_cnt = f_inc(r_cnt);
          end
        end
        default: w_state = IDLE;
      endcase

      // End of an entry's gap/space: next entry, repeat gap, or finish.
      if (w_advance) begin
        if (!w_last) begin
          w_load     = 1'b1;
          w_load_idx = r_idx + 1'b1;
        end else if (bus.repeat_en) begin
          w_state = REP_GAP;
          w_cnt   = '0;
        end else begin
          w_state = IDLE;
          w_cnt   = '0;
          w_idx   = '0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end
    end

    // Starting an entry: a zero-length entry is a word space.
    if (w_load) begin
      w_idx   = w_load_idx;
      w_cnt   = '0;
      w_state = (r_blen[w_load_idx] == '0) ? SPACE : CHAR;
    end

    // Outputs are looked up for the state being entered so they can be
    // registered without adding a unit of latency.
    if (w_state == CHAR) begin
      w_onoff = f_bit(r_pat[w_idx], r_blen[w_idx], int'(w_cnt));
      w_dash  = w_onoff & (f_bit(r_pat[w_idx], r_blen[w_idx], int'(w_cnt) - 1) |
                           f_bit(r_pat[w_idx], r_blen[w_idx], int'(w_cnt) + 1));
    end
  end

  // State and output registers
  always_ff @(posedge UnitClock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_msglen <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_onoff  <= 1'b0;
      r_dash   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_msglen <= w_msglen;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_onoff  <= w_onoff;
      r_dash   <= w_dash;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.char_idx = r_idx;
  assign bus.ONOFF    = r_onoff;
  assign bus.isDash   = r_dash;

endmodule

// File: tb/tb_morse_message_sequencer.sv
// tb_morse_message_sequencer
//   Testbench for morse_message_sequencer. A reference model expands the
//   buffer contents into the expected per-unit timeline (light on/off, dash,
//   entry index) and every cycle of playback is compared against it.
module tb_morse_message_sequencer;
  localparam int MAX_CHARS = 16;
  localparam int PAT_W     = 20;
  localparam int LEN_W     = 5;
  localparam int IDX_W     = 4;
  localparam int CHAR_GAP  = 3;
  localparam int WORD_GAP  = 7;
  localparam int GAP_MULT  = 2;
  localparam int ML_W      = IDX_W + 1;
`ifdef MORSE_FARNSWORTH_EN
  localparam int MULT = GAP_MULT;
  localparam int EXP_SOS_DONE = 40;
  localparam int EXP_WS_DONE  = 25;
  localparam int EXP_REP_DONE = 87;
`else
  localparam int MULT = 1;
  localparam int EXP_SOS_DONE = 31;
  localparam int EXP_WS_DONE  = 15;
  localparam int EXP_REP_DONE = 65;
`endif
  localparam int CG = CHAR_GAP * MULT;
  localparam int SG = (WORD_GAP - CHAR_GAP) * MULT;

  logic UnitClock;
  logic reset;
  int   checks = 0;
  int   errs   = 0;

  morse_message_sequencer_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .IDX_W(IDX_W)) bus ();

  morse_message_sequencer #(
    .MAX_CHARS(MAX_CHARS), .PAT_W(PAT_W), .LEN_W(LEN_W), .IDX_W(IDX_W),
    .CHAR_GAP(CHAR_GAP), .WORD_GAP(WORD_GAP), .GAP_MULT(GAP_MULT)
  ) dut (
    .UnitClock(UnitClock),
    .reset(reset),
    .bus(bus)
  );

  initial UnitClock = 1'b0;
  always #5 UnitClock = ~UnitClock;

  typedef struct { bit on; bit dash; int idx; } unit_t;
  unit_t            q[$];
  logic [PAT_W-1:0] m_pat [MAX_CHARS];
  int               m_len [MAX_CHARS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_unit(input bit on, input bit dash, input int idx);
    unit_t u;
    u.on = on; u.dash = dash; u.idx = idx;
    q.push_back(u);
  endtask

  // Expand the message into one record per Morse unit. A run of two or more
  // lit bits is a dash; a lone lit bit is a dot.
  task automatic build(input int leff, input int clr);
    q.delete();
    if (leff == 0) return;
    forever begin
      for (int e = 0; e < leff; e++) begin
        if (m_len[e] == 0) begin
          for (int k = 0; k < SG; k++) push_unit(1'b0, 1'b0, e);
        end else begin
          int i;
          i = 0;
          while (i < m_len[e]) begin
            if (m_pat[e][i]) begin
              int j;
              j = i;
              while (j < m_len[e] && m_pat[e][j]) j++;
              for (int k = i; k < j; k++) push_unit(1'b1, (j - i) >= 2, e);
              i = j;
            end else begin
              push_unit(1'b0, 1'b0, e);
              i++;
            end
          end
          for (int k = 0; k < CG; k++) push_unit(1'b0, 1'b0, e);
        end
      end
      // repeat_en is high during cycles below clr; the pass ends in cycle q.size()
      if (q.size() < clr) begin
        for (int k = 0; k < SG; k++) push_unit(1'b0, 1'b0, leff - 1);
      end else begin
        break;
      end
    end
  endtask

  task automatic wr(input int a, input logic [PAT_W-1:0] p, input int l);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = IDX_W'(a);
    bus.wr_pattern = p;
    bus.wr_len     = LEN_W'(l);
    @(posedge UnitClock); #2;
    bus.wr_en = 1'b0;
    m_pat[a] = p;
    m_len[a] = (l > PAT_W) ? PAT_W : l;
  endtask

  // Start playback in cycle 0 and compare every following cycle.
  // clr: repeat_en high for cycles < clr; ab: abort in that cycle (0 = none);
  // wl: attempt a buffer write in that cycle (0 = none).
  task automatic run_msg(input int l_in, input int clr, input int ab, input int wl,
                         output int done_cyc, output int ons, output int dashes);
    int    leff, n_end;
    unit_t u;
    logic  e_on, e_dash, e_busy, e_done;
    int    e_idx;
    leff = (l_in > MAX_CHARS) ? MAX_CHARS : l_in;
    build(leff, clr);
    done_cyc = 0; ons = 0; dashes = 0;
    n_end = (ab > 0) ? ab + 3 : q.size() + 2;
    bus.msg_len   = ML_W'(l_in);
    bus.start     = 1'b1;
    bus.repeat_en = (clr > 0);
    bus.abort     = 1'b0;
    for (int n = 1; n <= n_end; n++) begin
      @(posedge UnitClock); #2;
      e_on = 0; e_dash = 0; e_busy = 0; e_done = 0; e_idx = 0;
      if (ab > 0 && n > ab) begin
        e_busy = 0;
      end else if (n <= q.size()) begin
        u = q[n-1];
        e_on = u.on; e_dash = u.dash; e_idx = u.idx; e_busy = 1;
      end else if (n == q.size() + 1) begin
        e_done = 1;
      end
      chk("ONOFF",    32'(bus.ONOFF),    32'(e_on));
      chk("isDash",   32'(bus.isDash),   32'(e_dash));
      chk("busy",     32'(bus.busy),     32'(e_busy));
      chk("done",     32'(bus.done),     32'(e_done));
      chk("char_idx", 32'(bus.char_idx), 32'(e_idx));
      if (bus.done === 1'b1 && done_cyc == 0) done_cyc = n;
      if (bus.ONOFF === 1'b1) ons++;
      if (bus.isDash === 1'b1) dashes++;
      bus.start     = (n == 2 && q.size() > 2 && ab != 2);
      bus.repeat_en = (n < clr);
      bus.abort     = (n == ab);
      bus.wr_en     = (n == wl);
      if (n == wl) begin
        bus.wr_addr    = '0;
        bus.wr_pattern = PAT_W'($urandom);
        bus.wr_len     = LEN_W'(7);
      end
    end
    bus.start = 0; bus.abort = 0; bus.wr_en = 0; bus.repeat_en = 0;
  endtask

  task automatic write_sos();
    wr(0, PAT_W'(20'b10101), 5);
    wr(1, PAT_W'(20'b11101110111), 11);
    wr(2, PAT_W'(20'b10101), 5);
  endtask

  initial begin
    int dc, ons, dsh;
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_pattern = '0; bus.wr_len = '0;
    bus.msg_len = '0; bus.start = 0; bus.repeat_en = 0; bus.abort = 0;
    repeat (3) @(posedge UnitClock);
    #2;
    chk("rst_ONOFF",    32'(bus.ONOFF),    32'd0);
    chk("rst_isDash",   32'(bus.isDash),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_char_idx", 32'(bus.char_idx), 32'd0);
    reset = 1'b0;
    @(posedge UnitClock); #2;

    // SOS, with a write attempted while busy
    write_sos();
    run_msg(3, 0, 0, 10, dc, ons, dsh);
    chk("sos_done_cycle", 32'(dc),  32'(EXP_SOS_DONE));
    chk("sos_on_units",   32'(ons), 32'd15);
    chk("sos_dash_units", 32'(dsh), 32'd9);

    // Replay: entry 0 must be unchanged by the locked write
    run_msg(3, 0, 0, 0, dc, ons, dsh);
    chk("lock_done_cycle", 32'(dc),  32'(EXP_SOS_DONE));
    chk("lock_on_units",   32'(ons), 32'd15);

    // Repeat: repeat_en cleared during the second O
    run_msg(3, 48, 0, 0, dc, ons, dsh);
    chk("rep_done_cycle", 32'(dc),  32'(EXP_REP_DONE));
    chk("rep_on_units",   32'(ons), 32'd30);

    // Abort during O
    run_msg(3, 0, 12, 0, dc, ons, dsh);
    chk("abort_no_done", 32'(dc), 32'd0);

    // start and abort together: abort wins
    bus.msg_len = ML_W'(3); bus.start = 1; bus.abort = 1;
    @(posedge UnitClock); #2;
    chk("sa_busy",  32'(bus.busy),  32'd0);
    chk("sa_ONOFF", 32'(bus.ONOFF), 32'd0);
    chk("sa_done",  32'(bus.done),  32'd0);
    bus.start = 0; bus.abort = 0;
    @(posedge UnitClock); #2;
    chk("sa_busy2", 32'(bus.busy), 32'd0);

    // Empty message
    run_msg(0, 0, 0, 0, dc, ons, dsh);
    chk("empty_done_cycle", 32'(dc),  32'd1);
    chk("empty_on_units",   32'(ons), 32'd0);

    // Word space: E, space, T
    wr(0, PAT_W'(20'b1), 1);
    wr(1, PAT_W'(20'b0), 0);
    wr(2, PAT_W'(20'b111), 3);
    run_msg(3, 0, 0, 0, dc, ons, dsh);
    chk("ws_done_cycle", 32'(dc),  32'(EXP_WS_DONE));
    chk("ws_on_units",   32'(ons), 32'd4);

    // Randomized messages, including msg_len above MAX_CHARS and over-long lengths
    for (int it = 0; it < 8; it++) begin
      int l_in, clr;
      for (int e = 0; e < MAX_CHARS; e++)
        wr(e, PAT_W'($urandom), ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 31)));
      l_in = int'($urandom_range(1, 20));
      clr  = ($urandom % 2 == 1) ? int'($urandom_range(1, 400)) : 0;
      run_msg(l_in, clr, 0, 0, dc, ons, dsh);
      chk("rand_done_cycle", 32'(dc), 32'(q.size() + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
